// File: rtl/input_conditioner.sv
// Per-channel synchroniser, debouncer and edge detector for asynchronous button inputs.
// Define INPUT_CONDITIONER_REPEAT_EN to build the auto-repeat pulse generator; otherwise rpt is tied low.
module input_conditioner #(
    parameter int CHANNELS      = 6,
    parameter int DB_OVERFLOW   = 100000000,
    parameter int SYNC_STAGES   = 2,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] raw,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] rpt
);

    localparam int CW = $clog2(longint'(DB_OVERFLOW) + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_OVERFLOW - 1);

    typedef enum logic {
        ST_STABLE,
        ST_PENDING
    } db_state_t;

    if (CHANNELS < 1 || CHANNELS > 32 || DB_OVERFLOW < 1 || SYNC_STAGES < 2 ||
        SYNC_STAGES > 4 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("input_conditioner: illegal parameter value");
    end

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] sync_d [SYNC_STAGES];
    logic [CHANNELS-1:0] synced;
    logic [CW-1:0]       cnt_q  [CHANNELS];
    logic [CW-1:0]       cnt_d  [CHANNELS];
    db_state_t           state  [CHANNELS];
    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] rise_q, rise_d;
    logic [CHANNELS-1:0] fall_q, fall_d;

    always_comb begin
        sync_d[0] = raw;
        for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // State is implied by synced vs level; the counter only runs while they differ.
    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            cnt_d[ch] = '0;
            state[ch] = (synced[ch] == level_q[ch]) ? ST_STABLE : ST_PENDING;
            case (state[ch])
                ST_STABLE: cnt_d[ch] = '0;
                ST_PENDING: begin
                    if (cnt_q[ch] == DB_LAST) begin
                        level_d[ch] = ~level_q[ch];
                        rise_d[ch]  = ~level_q[ch];
                        fall_d[ch]  = level_q[ch];
                    end else begin
                        cnt_d[ch] = cnt_q[ch] + CW'(1);
                    end
                end
                default: cnt_d[ch] = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                cnt_q[ch] <= '0;
            end
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                cnt_q[ch] <= cnt_d[ch];
            end
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

`ifdef INPUT_CONDITIONER_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(longint'(RMAX) + 1);

    logic [RW-1:0]       rcnt_q [CHANNELS];
    logic [RW-1:0]       rcnt_d [CHANNELS];
    logic [CHANNELS-1:0] rpt_q, rpt_d;

    // Down-counter loaded on the rising edge; a pulse fires when it expires, then reloads with the period.
    always_comb begin
        rpt_d = '0;
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            rcnt_d[ch] = rcnt_q[ch];
            if (rise_d[ch]) begin
                rcnt_d[ch] = RW'(REPEAT_DELAY);
            end else if (!level_d[ch]) begin
                rcnt_d[ch] = '0;
            end else if (rcnt_q[ch] == RW'(1)) begin
                rpt_d[ch]  = 1'b1;
                rcnt_d[ch] = RW'(REPEAT_PERIOD);
            end else if (rcnt_q[ch] != '0) begin
                rcnt_d[ch] = rcnt_q[ch] - RW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                rcnt_q[ch] <= '0;
            end
            rpt_q <= '0;
        end else begin
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                rcnt_q[ch] <= rcnt_d[ch];
            end
            rpt_q <= rpt_d;
        end
    end

    assign rpt = rpt_q;
`else
    assign rpt = '0;
`endif

endmodule
